// File: rtl/bp_pkg.sv
// Shared widths, counter constants and helpers for the branch target predictor.
// The optional gshare indexing is selected with the BP_GSHARE_EN macro in the top.
package bp_pkg;

   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned IDX_W_DEF  = 6;
   localparam int unsigned TAG_W_DEF  = 8;
   localparam int unsigned CNT_W_DEF  = 2;
   localparam int unsigned GHR_W_DEF  = 6;

   // Counter helpers work on a fixed carrier wide enough for any supported CNT_W.
   localparam int unsigned CNT_MAX_W = 8;
   typedef logic [CNT_MAX_W-1:0] cnt_t;

   localparam logic [CNT_W_DEF-1:0] CNT_WEAK_T  = 2'b10;
   localparam logic [CNT_W_DEF-1:0] CNT_WEAK_NT = 2'b01;

   typedef struct packed {
      logic                  valid;
      logic [TAG_W_DEF-1:0]  tag;
      logic [ADDR_W_DEF-1:0] target;
   } btb_entry_t;

   function automatic cnt_t cnt_max(input int unsigned w);
      return cnt_t'((1 << w) - 1);
   endfunction

   // MSB set, remaining bits clear
   function automatic cnt_t cnt_weak_t(input int unsigned w);
      return cnt_t'(1 << (w - 1));
   endfunction

   // MSB clear, remaining bits set
   function automatic cnt_t cnt_weak_nt(input int unsigned w);
      return cnt_t'((1 << (w - 1)) - 1);
   endfunction

   function automatic cnt_t sat_inc(input cnt_t c, input int unsigned w);
      return (c >= cnt_max(w)) ? cnt_max(w) : c + cnt_t'(1);
   endfunction

   function automatic cnt_t sat_dec(input cnt_t c);
      return (c == '0) ? '0 : c - cnt_t'(1);
   endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped BTB storage: valid/tag/target per entry.
// One combinational lookup read, one probe read for the update path, one write.
module bp_btb
   import bp_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned IDX_W  = IDX_W_DEF,
   parameter int unsigned TAG_W  = TAG_W_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [IDX_W-1:0]  i_rd_idx,
   output logic              o_rd_valid,
   output logic [TAG_W-1:0]  o_rd_tag,
   output logic [ADDR_W-1:0] o_rd_target,
   input  logic [IDX_W-1:0]  i_pr_idx,
   output logic              o_pr_valid,
   output logic [TAG_W-1:0]  o_pr_tag,
   output logic [ADDR_W-1:0] o_pr_target,
   input  logic              i_wr_en,
   input  logic [IDX_W-1:0]  i_wr_idx,
   input  logic [TAG_W-1:0]  i_wr_tag,
   input  logic [ADDR_W-1:0] i_wr_target
);

   localparam int unsigned DEPTH = 1 << IDX_W;

   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic [ADDR_W-1:0] target;
   } entry_t;

   entry_t r_mem [DEPTH];
   entry_t w_rd;
   entry_t w_pr;

   // Entry array: cleared on reset, written with a valid entry on allocate/retarget
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[IDX_W'(i)] <= '0;
         end
      end else if (i_wr_en) begin
         r_mem[i_wr_idx] <= entry_t'{valid: 1'b1, tag: i_wr_tag, target: i_wr_target};
      end
   end

   // Both reads see pre-write contents
   always_comb begin
      w_rd        = r_mem[i_rd_idx];
      w_pr        = r_mem[i_pr_idx];
      o_rd_valid  = w_rd.valid;
      o_rd_tag    = w_rd.tag;
      o_rd_target = w_rd.target;
      o_pr_valid  = w_pr.valid;
      o_pr_tag    = w_pr.tag;
      o_pr_target = w_pr.target;
   end

endmodule

// File: rtl/branch_target_predictor.sv
// Fetch-stage branch target predictor: direct-mapped BTB plus saturating
// direction counters, trained from the EX-stage resolution port.
// Define BP_GSHARE_EN to index the counters with PC xor global history.
module branch_target_predictor
   import bp_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned IDX_W  = IDX_W_DEF,
   parameter int unsigned TAG_W  = TAG_W_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF,
   parameter int unsigned GHR_W  = GHR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] PCnow,
   output logic [ADDR_W-1:0] PCnext,
   output logic              pred_taken,
   input  logic              upd_valid,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic              upd_taken,
   input  logic [ADDR_W-1:0] upd_target,
   output logic              mispredict
);

   localparam int unsigned DEPTH = 1 << IDX_W;

   logic [IDX_W-1:0]  w_lk_idx;
   logic [TAG_W-1:0]  w_lk_tag;
   logic [IDX_W-1:0]  w_up_idx;
   logic [TAG_W-1:0]  w_up_tag;
   logic [IDX_W-1:0]  w_lk_cidx;
   logic [IDX_W-1:0]  w_up_cidx;

   logic              w_lk_valid;
   logic [TAG_W-1:0]  w_lk_btag;
   logic [ADDR_W-1:0] w_lk_target;
   logic              w_up_valid;
   logic [TAG_W-1:0]  w_up_btag;
   logic [ADDR_W-1:0] w_up_target;

   logic              w_lk_hit;
   logic              w_up_hit;
   logic [CNT_W-1:0]  w_lk_cnt;
   logic [CNT_W-1:0]  w_up_cnt;
   logic              w_up_pred;
   logic              w_up_wrong;
   logic              w_cnt_we;
   logic [CNT_W-1:0]  w_cnt_next;
   logic              w_btb_we;
   logic              w_unused;

   logic [CNT_W-1:0]  r_cnt [DEPTH];
   logic              r_mispredict;

   // Word-aligned PC fields; bits [1:0] and bits above the tag are not used
   assign w_lk_idx = PCnow[IDX_W+1:2];
   assign w_lk_tag = PCnow[IDX_W+2 +: TAG_W];
   assign w_up_idx = upd_pc[IDX_W+1:2];
   assign w_up_tag = upd_pc[IDX_W+2 +: TAG_W];
   assign w_unused = ^{PCnow, upd_pc};

`ifdef BP_GSHARE_EN
   logic [GHR_W-1:0] r_ghr;
   logic [IDX_W-1:0] w_ghr_pad;

   // History sits in the top bits of the counter index, zero padded below
   assign w_ghr_pad = IDX_W'(r_ghr) << (IDX_W - GHR_W);
   assign w_lk_cidx = w_lk_idx ^ w_ghr_pad;
   assign w_up_cidx = w_up_idx ^ w_ghr_pad;

   // Non-speculative global history: shift in each resolved direction
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ghr <= '0;
      end else if (upd_valid) begin
         r_ghr <= GHR_W'({r_ghr, upd_taken});
      end
   end
`else
   assign w_lk_cidx = w_lk_idx;
   assign w_up_cidx = w_up_idx;
`endif

   bp_btb #(
      .ADDR_W (ADDR_W),
      .IDX_W  (IDX_W),
      .TAG_W  (TAG_W)
   ) u_btb (
      .i_clk       (clk),
      .i_rst_n     (reset),
      .i_rd_idx    (w_lk_idx),
      .o_rd_valid  (w_lk_valid),
      .o_rd_tag    (w_lk_btag),
      .o_rd_target (w_lk_target),
      .i_pr_idx    (w_up_idx),
      .o_pr_valid  (w_up_valid),
      .o_pr_tag    (w_up_btag),
      .o_pr_target (w_up_target),
      .i_wr_en     (w_btb_we),
      .i_wr_idx    (w_up_idx),
      .i_wr_tag    (w_up_tag),
      .i_wr_target (upd_target)
   );

   // Zero-cycle fetch lookup against pre-update state
   always_comb begin
      w_lk_hit   = w_lk_valid && (w_lk_btag == w_lk_tag);
      w_lk_cnt   = r_cnt[w_lk_cidx];
      pred_taken = w_lk_hit && w_lk_cnt[CNT_W-1];
      PCnext     = pred_taken ? w_lk_target : PCnow + ADDR_W'(4);
   end

   // Re-lookup of the resolved branch and next counter value
   always_comb begin
      w_up_hit   = w_up_valid && (w_up_btag == w_up_tag);
      w_up_cnt   = r_cnt[w_up_cidx];
      w_up_pred  = w_up_hit && w_up_cnt[CNT_W-1];
      w_up_wrong = (w_up_pred != upd_taken) ||
                   (upd_taken && w_up_pred && (w_up_target != upd_target));
      w_cnt_we   = 1'b0;
      w_cnt_next = w_up_cnt;
      if (upd_valid) begin
         if (w_up_hit) begin
            w_cnt_we   = 1'b1;
            w_cnt_next = upd_taken ? CNT_W'(sat_inc(cnt_t'(w_up_cnt), CNT_W))
                                   : CNT_W'(sat_dec(cnt_t'(w_up_cnt)));
         end else if (upd_taken) begin
            w_cnt_we   = 1'b1;
            w_cnt_next = CNT_W'(cnt_weak_t(CNT_W));
         end
      end
      // Taken updates either allocate (miss) or refresh the target (hit)
      w_btb_we = upd_valid && upd_taken;
   end

   // Direction counter table
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_cnt[IDX_W'(i)] <= CNT_W'(cnt_weak_nt(CNT_W));
         end
      end else if (w_cnt_we) begin
         r_cnt[w_up_cidx] <= w_cnt_next;
      end
   end

   // One-cycle mispredict pulse for the previous cycle's update
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mispredict <= 1'b0;
      end else begin
         r_mispredict <= upd_valid && w_up_wrong;
      end
   end

   assign mispredict = r_mispredict;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed, table-driven bench for branch_target_predictor (default parameters).
module tb_branch_target_predictor;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] PCnow;
   logic [31:0] PCnext;
   logic        pred_taken;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        mispredict;

   int checks = 0;
   int errors = 0;

   branch_target_predictor dut (
      .clk        (clk),
      .reset      (reset),
      .PCnow      (PCnow),
      .PCnext     (PCnext),
      .pred_taken (pred_taken),
      .upd_valid  (upd_valid),
      .upd_pc     (upd_pc),
      .upd_taken  (upd_taken),
      .upd_target (upd_target),
      .mispredict (mispredict)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        uv;
      logic [31:0] upc;
      logic        ut;
      logic [31:0] utgt;
      logic [31:0] exp_next;
      logic        exp_pt;
      logic        exp_mp;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Apply inputs on the falling edge; checks follow 1 time unit later
   task automatic drive(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                        input logic ut, input logic [31:0] utgt);
      @(negedge clk);
      PCnow      = pc;
      upd_valid  = uv;
      upd_pc     = upc;
      upd_taken  = ut;
      upd_target = utgt;
      #1;
   endtask

   initial begin
      vec_t vecs [23];
      reset = 1'b0; PCnow = 32'h100; upd_valid = 1'b0;
      upd_pc = '0; upd_taken = 1'b0; upd_target = '0;

      #3;
      chk("rst_next", PCnext, 32'h104);
      chk("rst_pt", 32'(pred_taken), 32'd0);
      chk("rst_mp", 32'(mispredict), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rel_next", PCnext, 32'h104);
      chk("rel_pt", 32'(pred_taken), 32'd0);

`ifndef BP_GSHARE_EN
      //        pc            uv    upc           ut    utgt          next          pt    mp
      vecs[0]  = '{32'h100,      1'b0, 32'h0,        1'b0, 32'h0,   32'h104,      1'b0, 1'b0};
      vecs[1]  = '{32'h100,      1'b1, 32'h100,      1'b1, 32'h200, 32'h104,      1'b0, 1'b0};
      vecs[2]  = '{32'h100,      1'b0, 32'h0,        1'b0, 32'h0,   32'h200,      1'b1, 1'b1};
      vecs[3]  = '{32'h100,      1'b0, 32'h0,        1'b0, 32'h0,   32'h200,      1'b1, 1'b0};
      vecs[4]  = '{32'h100,      1'b1, 32'h100,      1'b0, 32'h0,   32'h200,      1'b1, 1'b0};
      vecs[5]  = '{32'h100,      1'b1, 32'h100,      1'b0, 32'h0,   32'h104,      1'b0, 1'b1};
      vecs[6]  = '{32'h100,      1'b1, 32'h100,      1'b0, 32'h0,   32'h104,      1'b0, 1'b0};
      vecs[7]  = '{32'h100,      1'b1, 32'h100,      1'b0, 32'h0,   32'h104,      1'b0, 1'b0};
      vecs[8]  = '{32'h100,      1'b1, 32'h100,      1'b1, 32'h200, 32'h104,      1'b0, 1'b0};
      vecs[9]  = '{32'h100,      1'b1, 32'h100,      1'b1, 32'h200, 32'h104,      1'b0, 1'b1};
      vecs[10] = '{32'h100,      1'b0, 32'h0,        1'b0, 32'h0,   32'h200,      1'b1, 1'b1};
      vecs[11] = '{32'h100,      1'b1, 32'h100,      1'b1, 32'h240, 32'h200,      1'b1, 1'b0};
      vecs[12] = '{32'h100,      1'b0, 32'h0,        1'b0, 32'h0,   32'h240,      1'b1, 1'b1};
      vecs[13] = '{32'h200,      1'b1, 32'h200,      1'b1, 32'h300, 32'h204,      1'b0, 1'b0};
      vecs[14] = '{32'h100,      1'b0, 32'h0,        1'b0, 32'h0,   32'h104,      1'b0, 1'b1};
      vecs[15] = '{32'h200,      1'b0, 32'h0,        1'b0, 32'h0,   32'h300,      1'b1, 1'b0};
      vecs[16] = '{32'h104,      1'b1, 32'h104,      1'b0, 32'h0,   32'h108,      1'b0, 1'b0};
      vecs[17] = '{32'h104,      1'b0, 32'h0,        1'b0, 32'h0,   32'h108,      1'b0, 1'b0};
      vecs[18] = '{32'h104,      1'b1, 32'h107,      1'b1, 32'h400, 32'h108,      1'b0, 1'b0};
      vecs[19] = '{32'h104,      1'b0, 32'h0,        1'b0, 32'h0,   32'h400,      1'b1, 1'b1};
      vecs[20] = '{32'hFFFFFFFC, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0,        1'b0, 1'b0};
      vecs[21] = '{32'hFFFFFFFC, 1'b1, 32'hFFFFFFFC, 1'b1, 32'h10,  32'h0,        1'b0, 1'b0};
      vecs[22] = '{32'hFFFFFFFC, 1'b0, 32'h0,        1'b0, 32'h0,   32'h10,       1'b1, 1'b1};

      for (int i = 0; i < 23; i++) begin
         drive(vecs[i].pc, vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].utgt);
         chk($sformatf("v%0d_next", i), PCnext, vecs[i].exp_next);
         chk($sformatf("v%0d_pt", i), 32'(pred_taken), 32'(vecs[i].exp_pt));
         chk($sformatf("v%0d_mp", i), 32'(mispredict), 32'(vecs[i].exp_mp));
      end

      // Asynchronous reset mid-run clears BTB and a pending mispredict pulse
      drive(32'h300, 1'b1, 32'h300, 1'b1, 32'h500);
      chk("mr_pre_next", PCnext, 32'h304);
      @(posedge clk);
      #1;
      upd_valid = 1'b0;
      chk("mr_mp_set", 32'(mispredict), 32'd1);
      chk("mr_hit_next", PCnext, 32'h500);
      #2;
      reset = 1'b0;
      #1;
      chk("mr_mp_clr", 32'(mispredict), 32'd0);
      chk("mr_rst_next", PCnext, 32'h304);
      chk("mr_rst_pt", 32'(pred_taken), 32'd0);
      drive(32'h300, 1'b1, 32'h300, 1'b1, 32'h500);
      @(negedge clk);
      reset     = 1'b1;
      upd_valid = 1'b0;
      #1;
      chk("mr_noupd_next", PCnext, 32'h304);
      drive(32'h200, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("mr_alias_next", PCnext, 32'h204);
      chk("mr_wrap_mp", 32'(mispredict), 32'd0);
      drive(32'hFFFFFFFC, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("mr_wrap_next", PCnext, 32'h0);
`else
      // Global history 1 vs 0 selects different counters for the same PC
      drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h200);
      chk("gs_pre_next", PCnext, 32'h104);
      drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("gs_h1_next", PCnext, 32'h104);
      chk("gs_h1_mp", 32'(mispredict), 32'd1);
      for (int i = 0; i < 6; i++) drive(32'h100, 1'b1, 32'h180, 1'b0, 32'h0);
      drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("gs_h0_next", PCnext, 32'h200);
      chk("gs_h0_pt", 32'(pred_taken), 32'd1);
      drive(32'h180, 1'b1, 32'h180, 1'b1, 32'h280);
      @(posedge clk);
      #3;
      upd_valid = 1'b0;
      reset     = 1'b0;
      #1;
      chk("gs_rst_next", PCnext, 32'h184);
      chk("gs_rst_mp", 32'(mispredict), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h200);
      for (int i = 0; i < 6; i++) drive(32'h100, 1'b1, 32'h180, 1'b0, 32'h0);
      drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("gs_ghr_clr_next", PCnext, 32'h200);
      drive(32'h180, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("gs_btb_clr_next", PCnext, 32'h184);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
